wino_tile_packer: RTL and testbench



---
 rtl/wino_tile_packer.sv | 127 ++++++++++++
 tb/tb_wino_tile_packer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wino_tile_packer.sv
// wino_tile_packer: packs one 25-byte Winograd tile (16 input + 9 weight bytes)
// into 14 words for the ALU B-operand slots. One word per handshake. With the
// marker enabled, every word carries bit 16 set and its own index in [20:17].
// That makes each word non-zero and different from the word before it, even
// when the tile bytes are all zero.
module wino_tile_packer #(
    parameter int CNT_W   = 16,
    parameter bit MARK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_index,
    output logic             out_last,
    output logic [CNT_W-1:0] tile_count
);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             half_q, half_d;   // first byte of a 2-byte word held
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       lo_q, lo_d;
    logic [CNT_W-1:0] tiles_q, tiles_d;

    logic             single_byte;
    logic [4:0]       mark_bits;

    // Words 9, 11 and 13 carry only one byte; their low byte stays zero.
    assign single_byte = (idx_q == 4'd9) || (idx_q == 4'd11) || (idx_q == 4'd13);

    if (MARK_EN) begin : g_mark
        assign mark_bits = {idx_q, 1'b1};
    end else begin : g_nomark
        assign mark_bits = 5'd0;
    end

    // Input and output phases never overlap. in_ready is gated by rst so it
    // reads 0 for the whole time reset is held.
    assign in_ready   = (state_q == FILL) && !rst;
    assign out_valid  = (state_q == SEND);
    assign out_data   = (state_q == SEND) ? {11'd0, mark_bits, hi_q, lo_q} : 32'd0;
    assign out_index  = idx_q;
    assign out_last   = (state_q == SEND) && (idx_q == 4'd13);
    assign tile_count = tiles_q;

    // Next-state logic. flush has priority over both handshakes, so a word
    // accepted in the same cycle as flush is dropped and not counted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        half_d  = half_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tiles_d = tiles_q;
        if (flush) begin
            state_d = FILL;
            idx_d   = 4'd0;
            half_d  = 1'b0;
            hi_d    = 8'd0;
            lo_d    = 8'd0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        if (!half_q) begin
                            hi_d = in_data;
                            lo_d = 8'd0;
                            if (single_byte) begin
                                state_d = SEND;
                            end else begin
                                half_d = 1'b1;
                            end
                        end else begin
                            lo_d    = in_data;
                            half_d  = 1'b0;
                            state_d = SEND;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        state_d = FILL;
                        half_d  = 1'b0;
                        if (idx_q == 4'd13) begin
                            idx_d   = 4'd0;
                            tiles_d = tiles_q + CNT_W'(1);
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= 4'd0;
            half_q  <= 1'b0;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            tiles_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tiles_q <= tiles_d;
        end
    end

endmodule

// File: tb/tb_wino_tile_packer.sv
// Directed bench for wino_tile_packer. Instance a uses the default build
// (marker on, 16-bit tile counter). Instance b has the marker off and a 2-bit
// counter, so counter wrap can be reached in a few tiles.
module tb_wino_tile_packer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        sel;

    logic        in_ready_a, out_valid_a, out_last_a;
    logic [31:0] out_data_a;
    logic [3:0]  out_index_a;
    logic [15:0] tile_count_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [31:0] out_data_b;
    logic [3:0]  out_index_b;
    logic [1:0]  tile_count_b;

    logic        in_ready_m, out_valid_m, out_last_m;
    logic [31:0] out_data_m;
    logic [3:0]  out_index_m;
    logic [15:0] tile_count_m;

    int          n_checks;
    int          n_errors;
    int          last_cyc;
    logic [7:0]  tb_bytes [25];
    logic [31:0] got_w [14];

    wino_tile_packer #(.CNT_W(16), .MARK_EN(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid & ~sel),
        .in_ready   (in_ready_a),
        .in_data    (in_data),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready & ~sel),
        .out_data   (out_data_a),
        .out_index  (out_index_a),
        .out_last   (out_last_a),
        .tile_count (tile_count_a)
    );

    wino_tile_packer #(.CNT_W(2), .MARK_EN(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid & sel),
        .in_ready   (in_ready_b),
        .in_data    (in_data),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready & sel),
        .out_data   (out_data_b),
        .out_index  (out_index_b),
        .out_last   (out_last_b),
        .tile_count (tile_count_b)
    );

    assign in_ready_m   = sel ? in_ready_b   : in_ready_a;
    assign out_valid_m  = sel ? out_valid_b  : out_valid_a;
    assign out_last_m   = sel ? out_last_b   : out_last_a;
    assign out_data_m   = sel ? out_data_b   : out_data_a;
    assign out_index_m  = sel ? out_index_b  : out_index_a;
    assign tile_count_m = sel ? {14'd0, tile_count_b} : tile_count_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word from the tile byte table: first byte index and byte count per slot.
    function automatic logic [31:0] exp_word(input int w, input bit mark);
        int         f;
        bit         two;
        logic [7:0] lo;
        logic [4:0] mk;
        two = 1'b1;
        case (w)
            9:       begin f = 18; two = 1'b0; end
            10:      f = 19;
            11:      begin f = 21; two = 1'b0; end
            12:      f = 22;
            13:      begin f = 24; two = 1'b0; end
            default: f = 2 * w;
        endcase
        lo = two ? tb_bytes[f+1] : 8'h00;
        mk = mark ? {w[3:0], 1'b1} : 5'd0;
        return {11'd0, mk, tb_bytes[f], lo};
    endfunction

    task automatic fill_seq(input logic [7:0] start);
        for (int i = 0; i < 25; i++) tb_bytes[i] = start + 8'(i);
    endtask

    // Offer nb bytes and accept nw_tgt words, one cycle per loop pass; optionally
    // hold out_ready low for stall_n cycles while word stall_idx is pending.
    task automatic stream(input int nb, input int nw_tgt, input int stall_idx,
                          input int stall_n, input bit mark);
        int          bi;
        int          nw;
        int          cyc;
        int          stall_left;
        bit          holding;
        logic [31:0] held;
        logic [31:0] prev;
        bi = 0; nw = 0; cyc = 0; stall_left = stall_n; holding = 1'b0;
        held = 32'd0; prev = 32'd0;
        while (!(bi >= nb && nw >= nw_tgt) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (in_ready_m && out_valid_m) begin
                n_errors++;
                $display("FAIL overlap: in_ready=%0b out_valid=%0b, required not both 1", in_ready_m, out_valid_m);
            end
            in_valid  = (bi < nb);
            in_data   = (bi < nb) ? tb_bytes[bi] : 8'h00;
            out_ready = (nw < nw_tgt);
            if (out_valid_m && stall_left > 0 && out_index_m == stall_idx[3:0]) begin
                out_ready = 1'b0;
                stall_left--;
                if (!holding) begin
                    held = out_data_m;
                    holding = 1'b1;
                end else begin
                    n_checks++;
                    if (out_data_m !== held) begin
                        n_errors++;
                        $display("FAIL stall_hold: out_data=%h required %h", out_data_m, held);
                    end
                end
                n_checks++;
                if (in_ready_m !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stall_in_ready: got %0b required 0", in_ready_m);
                end
            end
            if (in_valid && in_ready_m) bi++;
            if (out_valid_m && out_ready) begin
                got_w[nw] = out_data_m;
                n_checks++;
                if (out_data_m !== exp_word(nw, mark)) begin
                    n_errors++;
                    $display("FAIL word%0d: out_data=%h required %h", nw, out_data_m, exp_word(nw, mark));
                end
                n_checks++;
                if (out_index_m !== nw[3:0] || out_last_m !== (nw == 13)) begin
                    n_errors++;
                    $display("FAIL index%0d: out_index=%0d out_last=%0b required %0d %0b",
                             nw, out_index_m, out_last_m, nw, (nw == 13));
                end
                if (mark) begin
                    n_checks++;
                    if (out_data_m == 32'd0 || (nw > 0 && out_data_m == prev)) begin
                        n_errors++;
                        $display("FAIL distinct%0d: out_data=%h previous %h, required non-zero and different",
                                 nw, out_data_m, prev);
                    end
                end
                prev = out_data_m;
                nw++;
            end
        end
        last_cyc = cyc;
        if (cyc >= 400) begin
            n_errors++;
            $display("FAIL timeout: bytes=%0d words=%0d, required %0d %0d", bi, nw, nb, nw_tgt);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("stream: %0d bytes, %0d words, %0d cycles", bi, nw, cyc);
    endtask

    task automatic check_tc(input string name, input logic [15:0] req);
        n_checks++;
        if (tile_count_m !== req) begin
            n_errors++;
            $display("FAIL %s: tile_count=%0d required %0d", name, tile_count_m, req);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0 || out_data_m !== 32'd0 ||
            out_index_m !== 4'd0 || out_last_m !== 1'b0 || tile_count_m !== 16'd0) begin
            n_errors++;
            $display("FAIL reset: rdy=%0b vld=%0b data=%h idx=%0d last=%0b tc=%0d required 0 0 0 0 0 0",
                     in_ready_m, out_valid_m, out_data_m, out_index_m, out_last_m, tile_count_m);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_m !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: in_ready=%0b required 1", in_ready_m);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        fill_seq(8'h01);
        stream(25, 14, -1, 0, 1'b1);
        n_checks++;
        if (got_w[0] !== 32'h00010102 || got_w[1] !== 32'h00030304 || got_w[9] !== 32'h00131300 ||
            got_w[10] !== 32'h00151415 || got_w[13] !== 32'h001B1900) begin
            n_errors++;
            $display("FAIL basic_words: %h %h %h %h %h required 00010102 00030304 00131300 00151415 001b1900",
                     got_w[0], got_w[1], got_w[9], got_w[10], got_w[13]);
        end
        n_checks++;
        if (last_cyc !== 39) begin
            n_errors++;
            $display("FAIL basic_cycles: got %0d required 39", last_cyc);
        end
        check_tc("basic_tc", 16'd1);
    endtask

    task automatic test_stall();
        fill_seq(8'h01);
        stream(25, 14, 4, 5, 1'b1);
        n_checks++;
        if (got_w[4] !== 32'h0009090A) begin
            n_errors++;
            $display("FAIL stall_word4: got %h required 0009090a", got_w[4]);
        end
        n_checks++;
        if (last_cyc !== 44) begin
            n_errors++;
            $display("FAIL stall_cycles: got %0d required 44", last_cyc);
        end
        check_tc("stall_tc", 16'd2);
    endtask

    task automatic test_zero();
        for (int i = 0; i < 25; i++) tb_bytes[i] = 8'h00;
        stream(25, 14, -1, 0, 1'b1);
        n_checks++;
        if (got_w[0] !== 32'h00010000 || got_w[13] !== 32'h001B0000) begin
            n_errors++;
            $display("FAIL zero_words: %h %h required 00010000 001b0000", got_w[0], got_w[13]);
        end
        check_tc("zero_tc", 16'd3);
    endtask

    task automatic test_flush_partial();
        fill_seq(8'h01);
        stream(7, 3, -1, 0, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (out_index_m !== 4'd0 || in_ready_m !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_state: out_index=%0d in_ready=%0b required 0 1", out_index_m, in_ready_m);
        end
        check_tc("flush_tc_kept", 16'd3);
        fill_seq(8'hA0);
        stream(25, 14, -1, 0, 1'b1);
        n_checks++;
        if (got_w[0] !== 32'h0001A0A1) begin
            n_errors++;
            $display("FAIL flush_first: got %h required 0001a0a1", got_w[0]);
        end
        check_tc("flush_tc_after", 16'd4);
    endtask

    task automatic test_flush_discard();
        fill_seq(8'h40);
        stream(25, 13, -1, 0, 1'b1);
        n_checks++;
        if (out_valid_m !== 1'b1 || out_index_m !== 4'd13 || out_last_m !== 1'b1) begin
            n_errors++;
            $display("FAIL discard_pending: vld=%0b idx=%0d last=%0b required 1 13 1",
                     out_valid_m, out_index_m, out_last_m);
        end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (out_valid_m !== 1'b0 || out_index_m !== 4'd0) begin
            n_errors++;
            $display("FAIL discard_state: vld=%0b idx=%0d required 0 0", out_valid_m, out_index_m);
        end
        check_tc("discard_tc", 16'd4);
    endtask

    task automatic test_rst_mid_send();
        fill_seq(8'h01);
        stream(14, 6, -1, 0, 1'b1);
        n_checks++;
        if (out_valid_m !== 1'b1 || out_index_m !== 4'd6) begin
            n_errors++;
            $display("FAIL midsend_pending: vld=%0b idx=%0d required 1 6", out_valid_m, out_index_m);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b0 || out_index_m !== 4'd0) begin
            n_errors++;
            $display("FAIL midsend_rst: vld=%0b rdy=%0b idx=%0d required 0 0 0",
                     out_valid_m, in_ready_m, out_index_m);
        end
        check_tc("midsend_tc_cleared", 16'd0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_m !== 1'b1) begin
            n_errors++;
            $display("FAIL midsend_release: in_ready=%0b required 1", in_ready_m);
        end
        stream(25, 14, -1, 0, 1'b1);
        check_tc("midsend_tc_new", 16'd1);
    endtask

    task automatic test_wrap_nomark();
        sel = 1'b1;
        test_reset();
        fill_seq(8'h01);
        for (int t = 0; t < 4; t++) begin
            stream(25, 14, -1, 0, 1'b0);
            n_checks++;
            if (got_w[0] !== 32'h00000102 || got_w[13] !== 32'h00001900) begin
                n_errors++;
                $display("FAIL nomark_words: %h %h required 00000102 00001900", got_w[0], got_w[13]);
            end
            n_checks++;
            if (last_cyc !== 39) begin
                n_errors++;
                $display("FAIL b2b_cycles: got %0d required 39", last_cyc);
            end
            check_tc("wrap_tc", 16'((t + 1) % 4));
        end
        sel = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; last_cyc = 0;
        sel = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_flush_partial();
        test_flush_discard();
        test_rst_mid_send();
        test_wrap_nomark();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
